spi_slave_mcu: RTL and testbench

SPI_SLAVE_MCU -- requirements
Module: spi_slave_mcu

---
 rtl/spi_slave_mcu.sv | 109 ++++++++++
 tb/tb_spi_slave_mcu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mcu.sv
// IMU packet builder and SPI mode-0 slave: assembles a 16-byte packet from
// quaternion/gyro samples, flags new data on done, streams a snapshot on sdo.
module spi_slave_mcu #(
    parameter logic [7:0] HEADER = 8'hAA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sck,
    input  logic               sdi,
    output logic               sdo,
    input  logic               load,
    output logic               done,
    input  logic               quat1_valid,
    input  logic               gyro1_valid,
    input  logic signed [15:0] quat1_w,
    input  logic signed [15:0] quat1_x,
    input  logic signed [15:0] quat1_y,
    input  logic signed [15:0] quat1_z,
    input  logic signed [15:0] gyro1_x,
    input  logic signed [15:0] gyro1_y,
    input  logic signed [15:0] gyro1_z
);

    logic [7:0]   packet_buffer [0:15];
    logic         has_valid;
    logic         has_valid_prev_q;
    logic         arm_q;
    logic         done_q, done_d;
    logic         load_meta_q, load_sync_q, load_prev_q;
    logic         load_rise;
    logic [127:0] snapshot_q, snapshot_d;
    logic [7:0]   bit_cnt_q;
    logic         unused_sdi;

    assign unused_sdi = sdi;

    always_comb begin
        packet_buffer[0]  = HEADER;
        packet_buffer[1]  = quat1_w[15:8];
        packet_buffer[2]  = quat1_w[7:0];
        packet_buffer[3]  = quat1_x[15:8];
        packet_buffer[4]  = quat1_x[7:0];
        packet_buffer[5]  = quat1_y[15:8];
        packet_buffer[6]  = quat1_y[7:0];
        packet_buffer[7]  = quat1_z[15:8];
        packet_buffer[8]  = quat1_z[7:0];
        packet_buffer[9]  = gyro1_x[15:8];
        packet_buffer[10] = gyro1_x[7:0];
        packet_buffer[11] = gyro1_y[15:8];
        packet_buffer[12] = gyro1_y[7:0];
        packet_buffer[13] = gyro1_z[15:8];
        packet_buffer[14] = gyro1_z[7:0];
        packet_buffer[15] = {6'b0, gyro1_valid, quat1_valid};
    end

    assign has_valid = quat1_valid | gyro1_valid;
    assign load_rise = load_sync_q & ~load_prev_q;

    // arm_q blocks a set until has_valid has been seen low after reset, so a
    // sample already valid across reset release is not reported as new data.
    always_comb begin
        done_d = done_q;
        if (!has_valid || load_rise)
            done_d = 1'b0;
        else if (!has_valid_prev_q && arm_q)
            done_d = 1'b1;
    end

    always_comb begin
        snapshot_d = snapshot_q;
        if (load_rise) begin
            for (int i = 0; i < 16; i++)
                snapshot_d[127 - 8*i -: 8] = packet_buffer[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            has_valid_prev_q <= 1'b0;
            arm_q            <= 1'b0;
            done_q           <= 1'b0;
            load_meta_q      <= 1'b0;
            load_sync_q      <= 1'b0;
            load_prev_q      <= 1'b0;
            snapshot_q       <= '0;
        end else begin
            has_valid_prev_q <= has_valid;
            if (!has_valid)
                arm_q <= 1'b1;
            done_q           <= done_d;
            load_meta_q      <= load;
            load_sync_q      <= load_meta_q;
            load_prev_q      <= load_sync_q;
            snapshot_q       <= snapshot_d;
        end
    end

    // Pointer saturates at 128 so sdo idles low once the frame is exhausted.
    always_ff @(negedge sck or negedge load) begin
        if (!load)
            bit_cnt_q <= 8'd0;
        else if (bit_cnt_q != 8'd128)
            bit_cnt_q <= bit_cnt_q + 8'd1;
    end

    assign sdo  = (load && !bit_cnt_q[7]) ? snapshot_q[7'd127 - bit_cnt_q[6:0]] : 1'b0;
    assign done = done_q;

endmodule

// File: tb/tb_spi_slave_mcu.sv
// Directed self-checking bench for spi_slave_mcu.
module tb_spi_slave_mcu;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sck = 1'b0;
    logic               sdi = 1'b0;
    logic               sdo;
    logic               load = 1'b0;
    logic               done;
    logic               quat1_valid = 1'b0;
    logic               gyro1_valid = 1'b0;
    logic signed [15:0] quat1_w = '0, quat1_x = '0, quat1_y = '0, quat1_z = '0;
    logic signed [15:0] gyro1_x = '0, gyro1_y = '0, gyro1_z = '0;

    int total = 0;
    int bad   = 0;

    spi_slave_mcu dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .sdo(sdo),
        .load(load), .done(done),
        .quat1_valid(quat1_valid), .gyro1_valid(gyro1_valid),
        .quat1_w(quat1_w), .quat1_x(quat1_x), .quat1_y(quat1_y), .quat1_z(quat1_z),
        .gyro1_x(gyro1_x), .gyro1_y(gyro1_y), .gyro1_z(gyro1_z)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input logic [15:0] w, x, y, z, gx, gy, gz);
        quat1_w = w; quat1_x = x; quat1_y = y; quat1_z = z;
        gyro1_x = gx; gyro1_y = gy; gyro1_z = gz;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++;
        if (sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        total++;
        if (dut.snapshot_q !== 128'd0) begin bad++; $display("FAIL reset_snapshot got=%h exp=0", dut.snapshot_q); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_packet;
        logic [7:0] exp_b [0:14];
        exp_b = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                  8'hF0, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        set_data(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111, 16'h2222, 16'h3333);
        tick(2);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dut.packet_buffer[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL packet_byte%0d got=%h exp=%h", i, dut.packet_buffer[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_flags;
        logic [1:0] pat [0:2];
        logic [7:0] exp_b;
        pat = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            quat1_valid = pat[i][0];
            gyro1_valid = pat[i][1];
            exp_b = {6'b0, pat[i]};
            tick(2);
            total++;
            if (dut.packet_buffer[15] !== exp_b) begin
                bad++;
                $display("FAIL flags_byte15 q=%b g=%b got=%h exp=%h", pat[i][0], pat[i][1], dut.packet_buffer[15], exp_b);
            end
        end
        quat1_valid = 1'b0;
        gyro1_valid = 1'b0;
        tick(2);
    endtask

    task automatic test_done;
        tick(5);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_idle got=%b exp=0", done); end
        quat1_valid = 1'b1;
        tick(3);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_set got=%b exp=1", done); end
        quat1_valid = 1'b0;
        gyro1_valid = 1'b1;
        tick(4);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_swap got=%b exp=1", done); end
    endtask

    task automatic test_load_ack;
        load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b0) break;
            tick(1);
        end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b exp=0", done); end
        tick(2);
        load = 1'b0;
        tick(5);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL ack_hold got=%b exp=0", done); end
        gyro1_valid = 1'b0;
        tick(2);
        gyro1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) break;
            tick(1);
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL ack_reset got=%b exp=1", done); end
    endtask

    task automatic test_back_to_back;
        for (int p = 0; p < 2; p++) begin
            load = 1'b1;
            tick(2);
            load = 1'b0;
            tick(4);
        end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", done); end
    endtask

    task automatic test_quat_w;
        logic [15:0] wv [0:3];
        wv = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            quat1_w = wv[i];
            tick(2);
            total++;
            if ({dut.packet_buffer[1], dut.packet_buffer[2]} !== wv[i]) begin
                bad++;
                $display("FAIL quat_w got=%h%h exp=%h", dut.packet_buffer[1], dut.packet_buffer[2], wv[i]);
            end
        end
    endtask

    task automatic test_spi(input logic [15:0] w, x, y, z, gx, gy, gz, input logic qv, gv);
        logic [127:0] exp_s, cap;
        set_data(w, x, y, z, gx, gy, gz);
        quat1_valid = qv;
        gyro1_valid = gv;
        exp_s = {8'hAA, w, x, y, z, gx, gy, gz, 6'b0, gv, qv};
        cap = '0;
        tick(2);
        load = 1'b1;
        tick(4);
        for (int i = 0; i < 128; i++) begin
            #20 sck = 1'b1;
            #1  cap[127 - i] = sdo;
            #19 sck = 1'b0;
        end
        #5;
        total++;
        if (cap[127:120] !== 8'b10101010) begin bad++; $display("FAIL spi_header got=%b exp=10101010", cap[127:120]); end
        total++;
        if (cap !== exp_s) begin bad++; $display("FAIL spi_stream got=%h exp=%h", cap, exp_s); end
        total++;
        if (sdo !== 1'b0) begin bad++; $display("FAIL spi_tail got=%b exp=0", sdo); end
        load = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_coincident;
        quat1_valid = 1'b0;
        gyro1_valid = 1'b0;
        tick(3);
        reset = 1'b1;
        quat1_valid = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL rst_edge_ignored got=%b exp=0", done); end
        quat1_valid = 1'b0;
        tick(2);
        quat1_valid = 1'b1;
        tick(3);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL rst_new_edge got=%b exp=1", done); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_flags();
        test_done();
        test_load_ack();
        test_back_to_back();
        test_quat_w();
        test_spi(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1111, 16'h2222, 16'h3333, 1'b1, 1'b0);
        test_spi(16'h8001, 16'h0F0F, 16'hC3A5, 16'h7E81, 16'hFFFF, 16'h0001, 16'h5AA5, 1'b1, 1'b1);
        test_reset_coincident();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
